controller_poller: RTL and testbench

Parametrised multi-channel poller for NES/SNES-style serial game controllers. Drives one shared latch/pulse pair to NCH controllers and shifts NBITS button bits from each controller's data line in parallel, on a free-running period, on demand, or both. Each frame publishes per-channel active-high button vectors, one-cycle press/release strobes and a connected flag. It is the controller front end feeding game logic and the remote-link packetiser.

---
 rtl/controller_pkg.sv | 41 ++++
 rtl/controller_channel.sv | 64 ++++++
 rtl/controller_poller.sv | 157 +++++++++++++++
 tb/tb_controller_poller.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// Shared definitions for the controller poller: button bit positions inside a
// published vector, default timing constants and the frame state encoding.
package controller_pkg;

    // First bit shifted in lands at the MSB, so the NES A button is bit 7.
    localparam int NES_A      = 7;
    localparam int NES_B      = 6;
    localparam int NES_SELECT = 5;
    localparam int NES_START  = 4;
    localparam int NES_UP     = 3;
    localparam int NES_DOWN   = 2;
    localparam int NES_LEFT   = 1;
    localparam int NES_RIGHT  = 0;

    localparam int SNES_B      = 15;
    localparam int SNES_Y      = 14;
    localparam int SNES_SELECT = 13;
    localparam int SNES_START  = 12;
    localparam int SNES_UP     = 11;
    localparam int SNES_DOWN   = 10;
    localparam int SNES_LEFT   = 9;
    localparam int SNES_RIGHT  = 8;
    localparam int SNES_A      = 7;
    localparam int SNES_X      = 6;
    localparam int SNES_TL     = 5;
    localparam int SNES_TR     = 4;

    localparam int DEF_POLL_CYC  = 1_666_667;
    localparam int DEF_LATCH_CYC = 1200;
    localparam int DEF_HALF_CYC  = 600;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LATCH    = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_PULSE_LO = 3'd3,
        ST_PULSE_HI = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

endpackage

// File: rtl/controller_channel.sv
// One controller lane: synchroniser, button shift register, disconnect check
// and press/release edge detection against the previously published frame.
module controller_channel #(
    parameter int NBITS = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             data_i,
    input  logic             sample_i,
    input  logic             publish_i,
    output logic [NBITS-1:0] buttons_o,
    output logic [NBITS-1:0] pressed_o,
    output logic [NBITS-1:0] released_o,
    output logic             connected_o
);

    logic             sync1_q, sync2_q;
    logic [NBITS-1:0] shift_q, shift_d;
    logic [NBITS-1:0] btn_d;
    logic             conn_d;
    logic [NBITS-1:0] buttons_q, pressed_q, released_q;
    logic             connected_q;

    // Bits are stored inverted (pressed = 1); a line reading all-low looks
    // like every button held, which is really a missing controller.
    always_comb begin
        shift_d = shift_q;
        if (sample_i) begin
            shift_d = {shift_q[NBITS-2:0], ~sync2_q};
        end
        conn_d = ~(&shift_d);
        btn_d  = conn_d ? shift_d : '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            shift_q     <= '0;
            buttons_q   <= '0;
            pressed_q   <= '0;
            released_q  <= '0;
            connected_q <= 1'b0;
        end else begin
            sync1_q    <= data_i;
            sync2_q    <= sync1_q;
            shift_q    <= shift_d;
            pressed_q  <= '0;
            released_q <= '0;
            if (publish_i) begin
                buttons_q   <= btn_d;
                pressed_q   <= btn_d & ~buttons_q;
                released_q  <= ~btn_d & buttons_q;
                connected_q <= conn_d;
            end
        end
    end

    assign buttons_o   = buttons_q;
    assign pressed_o   = pressed_q;
    assign released_o  = released_q;
    assign connected_o = connected_q;

endmodule

// File: rtl/controller_poller.sv
// Multi-channel NES/SNES controller poller: frame FSM, period and phase
// counters, trigger/pending logic and the shared latch/pulse outputs.
module controller_poller
    import controller_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int NBITS     = 8,
    parameter int POLL_CYC  = DEF_POLL_CYC,
    parameter int LATCH_CYC = DEF_LATCH_CYC,
    parameter int HALF_CYC  = DEF_HALF_CYC,
    parameter int AUTO      = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NCH-1:0]       data_i,
    input  logic                 poll_req_i,
    output logic                 latch_o,
    output logic                 pulse_o,
    output logic                 busy_o,
    output logic                 valid_o,
    output logic [NCH*NBITS-1:0] buttons_o,
    output logic [NCH*NBITS-1:0] pressed_o,
    output logic [NCH*NBITS-1:0] released_o,
    output logic [NCH-1:0]       connected_o,
    output state_e               state_o
);

    localparam int PW   = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
    localparam int TMAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int BW   = (NBITS > 1) ? $clog2(NBITS) : 1;

    state_e          state_q, state_d;
    logic [PW-1:0]   poll_cnt_q, poll_cnt_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic            pend_q, pend_d;
    logic            tick, trig, sample, publish;

    // Free-running period; the tick lands on count 0 so the first auto frame
    // follows reset release immediately.
    assign poll_cnt_d = (poll_cnt_q == PW'(POLL_CYC - 1)) ? '0 : poll_cnt_q + 1'b1;
    assign tick       = (poll_cnt_q == '0);
    assign trig       = poll_req_i | ((AUTO != 0) & tick);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        bit_d   = bit_q;
        pend_d  = pend_q;
        sample  = 1'b0;
        publish = 1'b0;
        if (trig && (state_q != ST_IDLE)) begin
            pend_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (trig || pend_q) begin
                    state_d = ST_LATCH;
                    tmr_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            ST_LATCH: begin
                if (tmr_q == TW'(LATCH_CYC - 1)) begin
                    state_d = ST_SETTLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (tmr_q == TW'(HALF_CYC - 1)) begin
                    sample = 1'b1;
                    tmr_d  = '0;
                    bit_d  = BW'(1);
                    if (NBITS == 1) begin
                        publish = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_PULSE_LO;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_PULSE_LO: begin
                if (tmr_q == TW'(HALF_CYC - 1)) begin
                    state_d = ST_PULSE_HI;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_PULSE_HI: begin
                if (tmr_q == TW'(HALF_CYC - 1)) begin
                    sample = 1'b1;
                    tmr_d  = '0;
                    if (bit_q == BW'(NBITS - 1)) begin
                        publish = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        state_d = ST_PULSE_LO;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            poll_cnt_q <= '0;
            tmr_q      <= '0;
            bit_q      <= '0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            poll_cnt_q <= poll_cnt_d;
            tmr_q      <= tmr_d;
            bit_q      <= bit_d;
            pend_q     <= pend_d;
        end
    end

    assign latch_o = (state_q == ST_LATCH);
    assign pulse_o = (state_q != ST_PULSE_LO);
    assign busy_o  = (state_q != ST_IDLE);
    assign valid_o = (state_q == ST_DONE);
    assign state_o = state_q;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        controller_channel #(
            .NBITS(NBITS)
        ) u_ch (
            .clk_i      (clk_i),
            .rst_n_i    (rst_n_i),
            .data_i     (data_i[c]),
            .sample_i   (sample),
            .publish_i  (publish),
            .buttons_o  (buttons_o[c*NBITS +: NBITS]),
            .pressed_o  (pressed_o[c*NBITS +: NBITS]),
            .released_o (released_o[c*NBITS +: NBITS]),
            .connected_o(connected_o[c])
        );
    end

endmodule

// File: tb/tb_controller_poller.sv
// Bench for controller_poller: serial controller models, a frame scoreboard
// and one task per scenario.
module tb_controller_poller;
    import controller_pkg::*;

    localparam int EW = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        poll_req = 1'b0;
    logic [1:0]  data;
    logic        latch, pulse, busy, valid;
    logic [15:0] buttons, pressed, released;
    logic [1:0]  connected;
    state_e      state;

    logic        rst_n_a = 1'b0;
    logic        poll_req_a = 1'b0;
    logic [1:0]  data_a = 2'b11;
    logic        latch_a, pulse_a, busy_a, valid_a;
    logic [15:0] buttons_a, pressed_a, released_a;
    logic [1:0]  connected_a;
    state_e      state_a;

    logic [7:0]    raw [2];
    logic [1:0]    tie0 = 2'b00;
    logic [7:0]    prev_btn [2];
    logic [EW-1:0] exp_q [$];
    int            n_tests = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    controller_poller #(
        .NCH(2), .NBITS(8), .POLL_CYC(100), .LATCH_CYC(6), .HALF_CYC(3), .AUTO(0)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .poll_req_i(poll_req),
        .latch_o(latch), .pulse_o(pulse), .busy_o(busy), .valid_o(valid),
        .buttons_o(buttons), .pressed_o(pressed), .released_o(released),
        .connected_o(connected), .state_o(state)
    );

    controller_poller #(
        .NCH(2), .NBITS(8), .POLL_CYC(100), .LATCH_CYC(6), .HALF_CYC(3), .AUTO(1)
    ) dut_auto (
        .clk_i(clk), .rst_n_i(rst_n_a), .data_i(data_a), .poll_req_i(poll_req_a),
        .latch_o(latch_a), .pulse_o(pulse_a), .busy_o(busy_a), .valid_o(valid_a),
        .buttons_o(buttons_a), .pressed_o(pressed_a), .released_o(released_a),
        .connected_o(connected_a), .state_o(state_a)
    );

    // Controller model: latch loads the raw byte, MSB on the line first;
    // each pulse rising edge shifts the next bit out.
    for (genvar c = 0; c < 2; c++) begin : g_model
        logic [7:0] sr = 8'hFF;
        always @(posedge latch or posedge pulse) begin
            if (latch) sr = raw[c];
            else       sr = {sr[6:0], 1'b1};
        end
        assign data[c] = tie0[c] ? 1'b0 : sr[7];
    end

    task automatic push_exp();
        logic [15:0] b, p, r;
        logic [1:0]  cn;
        for (int c = 0; c < 2; c++) begin
            logic [7:0] eff, nb;
            eff   = tie0[c] ? 8'h00 : raw[c];
            cn[c] = (eff != 8'h00);
            nb    = cn[c] ? ~eff : 8'h00;
            b[c*8 +: 8] = nb;
            p[c*8 +: 8] = nb & ~prev_btn[c];
            r[c*8 +: 8] = ~nb & prev_btn[c];
            prev_btn[c] = nb;
        end
        exp_q.push_back({cn, r, p, b});
    endtask

    task automatic start_frame();
        @(negedge clk);
        poll_req = 1'b1;
        @(negedge clk);
        poll_req = 1'b0;
    endtask

    // Entered at the negedge of frame cycle 0; leaves at the negedge after valid.
    task automatic check_frame(input string tag, input bit extra_req);
        int            cyc;
        int            falls;
        logic          prev_pulse;
        logic [EW-1:0] e;
        cyc = 0;
        falls = 0;
        n_tests++;
        if (latch !== 1'b1) begin
            n_fail++;
            $display("FAIL %s latch_start: got %b want 1", tag, latch);
        end
        prev_pulse = pulse;
        while (valid !== 1'b1 && cyc < 200) begin
            poll_req = extra_req && (cyc == 5 || cyc == 20 || cyc == 35);
            @(negedge clk);
            cyc++;
            if (prev_pulse === 1'b1 && pulse === 1'b0) falls++;
            prev_pulse = pulse;
        end
        poll_req = 1'b0;
        n_tests++;
        if (cyc !== 51) begin
            n_fail++;
            $display("FAIL %s valid_cycle: got %0d want 51", tag, cyc);
        end
        n_tests++;
        if (falls !== 7) begin
            n_fail++;
            $display("FAIL %s pulse_lows: got %0d want 7", tag, falls);
        end
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard_empty: got 0 entries want 1", tag);
        end else begin
            e = exp_q.pop_front();
            if (buttons !== e[15:0]) begin
                n_fail++;
                $display("FAIL %s buttons: got %h want %h", tag, buttons, e[15:0]);
            end
            n_tests++;
            if (pressed !== e[31:16]) begin
                n_fail++;
                $display("FAIL %s pressed: got %h want %h", tag, pressed, e[31:16]);
            end
            n_tests++;
            if (released !== e[47:32]) begin
                n_fail++;
                $display("FAIL %s released: got %h want %h", tag, released, e[47:32]);
            end
            n_tests++;
            if (connected !== e[49:48]) begin
                n_fail++;
                $display("FAIL %s connected: got %b want %b", tag, connected, e[49:48]);
            end
        end
        @(negedge clk);
        n_tests++;
        if ({valid, pressed, released} !== 33'd0) begin
            n_fail++;
            $display("FAIL %s strobes_after: got v=%b p=%h r=%h want 0", tag, valid, pressed, released);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({latch, pulse, busy, valid} !== 4'b0100 || buttons !== 16'h0 ||
            pressed !== 16'h0 || released !== 16'h0 || connected !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_state: got l=%b p=%b b=%b v=%b btn=%h c=%b want pulse only",
                     latch, pulse, busy, valid, buttons, connected);
        end
        prev_btn[0] = 8'h00;
        prev_btn[1] = 8'h00;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        raw[0] = 8'h7E;
        raw[1] = 8'hFF;
        push_exp();
        start_frame();
        check_frame("basic", 1'b0);
    endtask

    task automatic test_edges();
        logic [7:0] pat [3];
        pat[0] = 8'h00;
        pat[1] = 8'h05;
        pat[2] = 8'h04;
        for (int i = 0; i < 3; i++) begin
            raw[0] = ~pat[i];
            raw[1] = 8'hFF;
            push_exp();
            start_frame();
            check_frame($sformatf("edges_f%0d", i + 1), 1'b0);
        end
    endtask

    task automatic test_disconnect();
        tie0   = 2'b10;
        raw[0] = 8'h7E;
        raw[1] = 8'h3C;
        push_exp();
        start_frame();
        check_frame("disconnect", 1'b0);
        tie0 = 2'b00;
    endtask

    task automatic test_back_to_back();
        int rises;
        logic prev_l;
        raw[0] = 8'hB7;
        raw[1] = 8'hFF;
        push_exp();
        push_exp();
        start_frame();
        check_frame("b2b_first", 1'b1);
        n_tests++;
        if (busy !== 1'b0 || latch !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle_gap: got busy=%b latch=%b want 0 0", busy, latch);
        end
        @(negedge clk);
        check_frame("b2b_second", 1'b0);
        rises = 0;
        prev_l = latch;
        repeat (150) begin
            @(negedge clk);
            if (!prev_l && latch) rises++;
            prev_l = latch;
        end
        n_tests++;
        if (rises !== 0) begin
            n_fail++;
            $display("FAIL b2b_extra_frames: got %0d want 0", rises);
        end
    endtask

    task automatic test_auto();
        int rises, valids, bad_gap, last_rise;
        logic prev_l;
        rst_n_a = 1'b0;
        repeat (2) @(negedge clk);
        rst_n_a = 1'b1;
        rises = 0;
        valids = 0;
        bad_gap = 0;
        last_rise = -1;
        prev_l = latch_a;
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            if (valid_a === 1'b1) valids++;
            if (!prev_l && latch_a === 1'b1) begin
                rises++;
                if (last_rise >= 0 && (i - last_rise) != 100) bad_gap++;
                last_rise = i;
            end
            prev_l = latch_a;
        end
        n_tests++;
        if (valids !== 10) begin
            n_fail++;
            $display("FAIL auto_valid_count: got %0d want 10", valids);
        end
        n_tests++;
        if (rises !== 10) begin
            n_fail++;
            $display("FAIL auto_latch_count: got %0d want 10", rises);
        end
        n_tests++;
        if (bad_gap !== 0) begin
            n_fail++;
            $display("FAIL auto_period: got %0d bad gaps want 0", bad_gap);
        end
    endtask

    task automatic test_reset_mid();
        raw[0] = 8'h7E;
        raw[1] = 8'hFF;
        start_frame();
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({latch, pulse, busy, valid} !== 4'b0100 || buttons !== 16'h0 || connected !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid: got l=%b p=%b b=%b v=%b btn=%h c=%b want pulse only",
                     latch, pulse, busy, valid, buttons, connected);
        end
        repeat (3) @(negedge clk);
        prev_btn[0] = 8'h00;
        prev_btn[1] = 8'h00;
        rst_n = 1'b1;
        @(negedge clk);
        push_exp();
        start_frame();
        check_frame("after_reset", 1'b0);
    endtask

    initial begin
        raw[0] = 8'hFF;
        raw[1] = 8'hFF;
        prev_btn[0] = 8'h00;
        prev_btn[1] = 8'h00;
        test_reset();
        test_basic();
        test_edges();
        test_disconnect();
        test_back_to_back();
        test_auto();
        test_reset_mid();
        n_tests++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
